gs_butterfly_half: RTL and testbench

GS_BUTTERFLY_HALF -- requirements
Module: gs_butterfly_half

---
 rtl/gs_butterfly_half_pkg.sv | 10 +
 rtl/barrett_reduce.sv | 62 ++++++
 rtl/gs_butterfly_half.sv | 127 ++++++++++++
 tb/tb_gs_butterfly_half.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_butterfly_half_pkg.sv
// Shared NTT constants for q = 3329: modulus, inverse of 2, and the Barrett
// reciprocal/shift pair used by both forward and inverse butterflies.
package gs_butterfly_half_pkg;

    localparam int NTT_Q      = 3329;
    localparam int NTT_HALF_Q = (NTT_Q + 1) / 2;
    localparam int NTT_MU     = 5039;
    localparam int NTT_SHIFT  = 24;

endpackage

// File: rtl/barrett_reduce.sv
// Two-stage Barrett reduction of a 2*data_width-bit product modulo M.
// The stage advances only while en is high; the result register is the output.
module barrett_reduce
    import gs_butterfly_half_pkg::*;
#(
    parameter int data_width = 12,
    parameter int M          = NTT_Q,
    parameter int MU         = NTT_MU,
    parameter int SHIFT      = NTT_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [2*data_width-1:0] p,
    output logic [data_width-1:0]   r
);

    localparam int DW = data_width;
    localparam int PW = 2 * data_width;
    localparam int TW = data_width + 1;
    localparam int XW = PW + TW;

    logic [XW-1:0] prod_s;
    logic [TW-1:0] t_s;
    logic [PW-1:0] rem_s;
    logic [DW-1:0] r_s;
    logic [PW-1:0] p_r;
    logic [TW-1:0] t_r;
    logic [DW-1:0] r_r;

    // Quotient estimate; never exceeds floor(p/M), so the remainder is non-negative.
    always_comb begin
        prod_s = XW'(p) * XW'(MU);
        t_s    = TW'(prod_s >> SHIFT);
    end

    // The estimate is off by at most one, leaving the remainder in [0, 2M).
    always_comb begin
        rem_s = p_r - (PW'(t_r) * PW'(M));
        if (rem_s >= PW'(M)) begin
            r_s = DW'(rem_s - PW'(M));
        end else begin
            r_s = DW'(rem_s);
        end
    end

    // Quotient stage followed by the corrected-remainder stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r <= '0;
            t_r <= '0;
            r_r <= '0;
        end else if (en) begin
            p_r <= p;
            t_r <= t_s;
            r_r <= r_s;
        end
    end

    assign r = r_r;

endmodule

// File: rtl/gs_butterfly_half.sv
// Inverse-NTT Gentleman-Sande butterfly with the 1/2 scaling folded in:
// u = (a+b)/2, v = ((a-b)/2)*w mod M, as a 4-stage stallable pipeline.
module gs_butterfly_half
    import gs_butterfly_half_pkg::*;
#(
    parameter int data_width = 12,
    parameter int M          = NTT_Q
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    input  logic [data_width-1:0] w,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] u,
    output logic [data_width-1:0] v
);

    localparam int DW = data_width;
    localparam int PW = 2 * data_width;
    localparam logic [DW:0]   m_ext_c = (DW + 1)'(M);
    localparam logic [DW-1:0] half_c  = DW'(NTT_HALF_Q);

    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] sum_v;
        sum_v = {1'b0, x} + {1'b0, y};
        if (sum_v >= m_ext_c) begin
            sum_v = sum_v - m_ext_c;
        end else begin
            sum_v = sum_v;
        end
        return sum_v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] diff_v;
        if (x < y) begin
            diff_v = {1'b0, x} + m_ext_c - {1'b0, y};
        end else begin
            diff_v = {1'b0, x} - {1'b0, y};
        end
        return diff_v[DW-1:0];
    endfunction

    // Odd values borrow M so the result stays an exact modular half below M.
    function automatic logic [DW-1:0] mod_half(input logic [DW-1:0] x);
        logic [DW-1:0] res_v;
        if (x[0]) begin
            res_v = (x >> 1) + half_c;
        end else begin
            res_v = x >> 1;
        end
        return res_v;
    endfunction

    logic          adv_s;
    logic [PW-1:0] p_s;
    logic          v1_r;
    logic [DW-1:0] s1_r;
    logic [DW-1:0] d1_r;
    logic [DW-1:0] w1_r;
    logic          v2_r;
    logic [DW-1:0] hu2_r;
    logic [PW-1:0] p2_r;
    logic          v3_r;
    logic [DW-1:0] hu3_r;
    logic          v4_r;
    logic [DW-1:0] u_r;
    logic [DW-1:0] bar_r_s;

    // Whole pipeline moves together; it only freezes when a result is stuck at the output.
    always_comb begin
        adv_s = !v4_r || out_ready;
        p_s   = PW'(mod_half(d1_r)) * PW'(w1_r);
    end

    // Stage registers S1..S4 for the valid bits and the non-Barrett data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r  <= 1'b0;
            s1_r  <= '0;
            d1_r  <= '0;
            w1_r  <= '0;
            v2_r  <= 1'b0;
            hu2_r <= '0;
            p2_r  <= '0;
            v3_r  <= 1'b0;
            hu3_r <= '0;
            v4_r  <= 1'b0;
            u_r   <= '0;
        end else if (adv_s) begin
            v1_r  <= in_valid;
            s1_r  <= mod_add(a, b);
            d1_r  <= mod_sub(a, b);
            w1_r  <= w;
            v2_r  <= v1_r;
            hu2_r <= mod_half(s1_r);
            p2_r  <= p_s;
            v3_r  <= v2_r;
            hu3_r <= hu2_r;
            v4_r  <= v3_r;
            u_r   <= hu3_r;
        end
    end

    barrett_reduce #(
        .data_width (data_width),
        .M          (M),
        .MU         (NTT_MU),
        .SHIFT      (NTT_SHIFT)
    ) u_barrett (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv_s),
        .p     (p2_r),
        .r     (bar_r_s)
    );

    assign in_ready  = adv_s;
    assign out_valid = v4_r;
    assign u         = u_r;
    assign v         = bar_r_s;

endmodule

// File: tb/tb_gs_butterfly_half.sv
// Scoreboard bench for gs_butterfly_half: golden results are queued at accept
// and compared when the DUT hands a result to the consumer.
module tb_gs_butterfly_half;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] w;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] u;
    logic [11:0] v;

    int          n_vec;
    int          n_miss;
    logic [23:0] sb[$];
    logic        rnd_done;
    logic [11:0] hold_u;
    logic [11:0] hold_v;
    int          lat;

    gs_butterfly_half #(.data_width(12), .M(3329)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .u         (u),
        .v         (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] golden(input int ta, input int tb, input int tw);
        int uu;
        int dd;
        int vv;
        uu = ((ta + tb) * 1665) % 3329;
        dd = (ta - tb + 3329) % 3329;
        vv = (((dd * tw) % 3329) * 1665) % 3329;
        return {12'(uu), 12'(vv)};
    endfunction

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_val("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    logic [23:0] e;
                    e = sb.pop_front();
                    check_val("u", 32'(u), 32'(e[23:12]));
                    check_val("v", 32'(v), 32'(e[11:0]));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(golden(int'(a), int'(b), int'(w)));
            end
        end
    end

    task automatic send(input logic [11:0] ta, input logic [11:0] tb, input logic [11:0] tw);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        w = tw;
        do begin
            @(negedge clk);
            guard++;
        end while (!in_ready && guard < 200);
        if (guard >= 200) begin
            check_val("send_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_val("sb_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 12'd0;
        b         = 12'd0;
        w         = 12'd0;
        rnd_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_u", 32'(u), 32'd0);
        check_val("rst_v", 32'(v), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency and first directed vector.
        in_valid = 1'b1;
        a = 12'd5;
        b = 12'd3;
        w = 12'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("latency", 32'(lat), 32'd4);
        check_val("u_5_3", 32'(u), 32'd4);
        check_val("v_5_3", 32'(v), 32'd1);
        drain();

        // Boundary vectors with fixed expected values.
        send(12'd0, 12'd1, 12'd1);
        repeat (3) @(posedge clk);
        #1;
        check_val("u_0_1", 32'(u), 32'd1665);
        check_val("v_0_1", 32'(v), 32'd1664);
        send(12'd3328, 12'd3328, 12'd3328);
        repeat (3) @(posedge clk);
        #1;
        check_val("u_max", 32'(u), 32'd3328);
        check_val("v_max", 32'(v), 32'd0);
        send(12'd2, 12'd0, 12'd17);
        repeat (3) @(posedge clk);
        #1;
        check_val("u_2_0", 32'(u), 32'd1);
        check_val("v_2_0", 32'(v), 32'd17);
        drain();

        // Back-to-back stream with a 3-cycle output stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(12'($urandom_range(3328, 0)), 12'($urandom_range(3328, 0)),
                         12'($urandom_range(3328, 0)));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                hold_u = u;
                hold_v = v;
                check_val("stall_ov", 32'(out_valid), 32'd1);
                check_val("stall_rdy0", 32'(in_ready), 32'd0);
                for (int k = 1; k < 3; k++) begin
                    @(negedge clk);
                    check_val("stall_rdy", 32'(in_ready), 32'd0);
                    check_val("stall_u", 32'(u), 32'(hold_u));
                    check_val("stall_v", 32'(v), 32'(hold_v));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three butterflies in flight.
        send(12'd100, 12'd200, 12'd300);
        send(12'd7, 12'd9, 12'd11);
        send(12'd1234, 12'd42, 12'd999);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_val("mid_rst_ov", 32'(out_valid), 32'd0);
        check_val("mid_rst_u", 32'(u), 32'd0);
        check_val("mid_rst_v", 32'(v), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_val("post_rst_ov", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random operands with random consumer backpressure.
        fork
            begin
                for (int i = 0; i < 20000; i++) begin
                    if ($urandom_range(3, 0) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(12'($urandom_range(3328, 0)), 12'($urandom_range(3328, 0)),
                         12'($urandom_range(3328, 0)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(3, 0) != 0);
                end
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
